// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Produces one product or quotient bit per cycle, then applies signs in a single fix-up cycle.
module mul_div_unit #(
    parameter int unsigned size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [size-1:0] src1_i,
    input  logic [size-1:0] src2_i,
    input  logic            mthi_i,
    input  logic            mtlo_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            div_zero_o,
    output logic [size-1:0] hi_o,
    output logic [size-1:0] lo_o
);
    localparam int unsigned CntW = (size > 1) ? $clog2(size) : 1;

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    state_e            state_q;
    logic [1:0]        op_q;      // [1]: divide, [0]: unsigned
    logic              sign1_q;   // dividend / multiplicand was negative (signed ops only)
    logic              sign2_q;
    logic [CntW-1:0]   cnt_q;
    logic [size-1:0]   opb_q;     // multiplicand or divisor magnitude
    logic [2*size-1:0] acc_q;     // product accumulator; low half is dividend/quotient on divide
    logic [size-1:0]   rem_q;
    logic [size-1:0]   hi_q;
    logic [size-1:0]   lo_q;
    logic              done_q;
    logic              div_zero_q;

    logic              is_signed_in;
    logic [size-1:0]   abs1;
    logic [size-1:0]   abs2;
    logic [size:0]     mul_sum;
    logic [2*size-1:0] mul_next;
    logic [size:0]     div_shift;
    logic [size+1:0]   div_diff;
    logic              div_ok;
    logic [size-1:0]   rem_next;
    logic [size-1:0]   quo_next;
    logic              neg_res;
    logic [2*size-1:0] prod_fix;
    logic [size-1:0]   quo_fix;
    logic [size-1:0]   rem_fix;
    logic              div_by_zero;
    logic [size-1:0]   fix_hi;
    logic [size-1:0]   fix_lo;
    logic              unused_div_bit;

    // Operand magnitudes at launch, one iteration step, and the sign fix-up of the result.
    always_comb begin
        is_signed_in = ~op_i[0];
        abs1 = (is_signed_in && src1_i[size-1]) ? -src1_i : src1_i;
        abs2 = (is_signed_in && src2_i[size-1]) ? -src2_i : src2_i;

        // Shift-add: add multiplicand into the upper half when the multiplier LSB is set.
        mul_sum  = {1'b0, acc_q[2*size-1:size]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[size-1:1]};

        // Restoring step on a size+1 bit partial remainder; the kept remainder always fits
        // in size bits because it stays below the divisor.
        div_shift      = {rem_q, acc_q[size-1]};
        div_diff       = {1'b0, div_shift} - {2'b00, opb_q};
        div_ok         = ~div_diff[size+1];
        rem_next       = div_ok ? div_diff[size-1:0] : div_shift[size-1:0];
        quo_next       = {acc_q[size-2:0], div_ok};
        unused_div_bit = div_diff[size];

        neg_res     = sign1_q ^ sign2_q;
        prod_fix    = neg_res ? -acc_q : acc_q;
        quo_fix     = neg_res ? -acc_q[size-1:0] : acc_q[size-1:0];
        // With a zero divisor the remainder is the dividend magnitude, so re-signing it
        // restores the raw dividend bits for HI.
        rem_fix     = sign1_q ? -rem_q : rem_q;
        div_by_zero = (opb_q == '0);

        if (op_q[1]) begin
            fix_hi = rem_fix;
            fix_lo = div_by_zero ? '1 : quo_fix;
        end else begin
            fix_hi = prod_fix[2*size-1:size];
            fix_lo = prod_fix[size-1:0];
        end
    end

    // Control FSM, iteration datapath and the architectural HI/LO/status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            op_q       <= 2'b00;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            cnt_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q    <= op_i;
                        sign1_q <= is_signed_in & src1_i[size-1];
                        sign2_q <= is_signed_in & src2_i[size-1];
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        if (op_i[1]) begin
                            acc_q <= {{size{1'b0}}, abs1};
                            opb_q <= abs2;
                        end else begin
                            acc_q <= {{size{1'b0}}, abs2};
                            opb_q <= abs1;
                        end
                        state_q <= StIter;
                    end else begin
                        if (mthi_i) hi_q <= src1_i;
                        if (mtlo_i) lo_q <= src1_i;
                        state_q <= StIdle;
                    end
                end
                StIter: begin
                    if (op_q[1]) begin
                        rem_q            <= rem_next;
                        acc_q[size-1:0]  <= quo_next;
                    end else begin
                        acc_q <= mul_next;
                    end
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(size - 1)) state_q <= StFix;
                end
                StFix: begin
                    hi_q       <= fix_hi;
                    lo_q       <= fix_lo;
                    done_q     <= 1'b1;
                    div_zero_q <= op_q[1] & div_by_zero;
                    state_q    <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Status and HI/LO come straight from registers.
    always_comb begin
        busy_o     = (state_q == StIter) || (state_q == StFix);
        done_o     = done_q;
        div_zero_o = div_zero_q;
        hi_o       = hi_q;
        lo_o       = lo_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus randomized traffic checked every cycle
// against an arithmetic reference model of HI/LO, busy and done timing.
module tb_mul_div_unit;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         mthi;
    logic         mtlo;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad = 0;
    int nprint = 0;
    logic chk_on = 1'b0;

    // Reference state: cycles of busy remaining, visible outputs, pending result.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic        m_dz = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    logic        p_dz = 1'b0;

    always #5 clk = ~clk;

    mul_div_unit #(.size(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .src1_i     (src1),
        .src2_i     (src2),
        .mthi_i     (mthi),
        .mtlo_i     (mtlo),
        .busy_o     (busy),
        .done_o     (done),
        .div_zero_o (dz),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // Architectural result of one operation, straight from the instruction semantics.
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] rh,
                                   output logic [31:0] rl, output logic rdz);
        logic [63:0] p;
        int sa;
        int sb;
        rdz = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    rh = a;
                    rl = 32'hffff_ffff;
                    rdz = 1'b1;
                end else if (o == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
                        rl = 32'h8000_0000;
                        rh = 32'd0;
                    end else begin
                        sa = $signed(a);
                        sb = $signed(b);
                        rl = sa / sb;
                        rh = sa % sb;
                    end
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
        endcase
    endfunction

    // Cycle-level reference: busy for W+1 cycles after an accepted start, then a done pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_dz = 1'b0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    m_dz = p_dz;
                    m_done = 1'b1;
                end
            end else if (start) begin
                ref_op(op, src1, src2, p_hi, p_lo, p_dz);
                m_left = W + 1;
            end else begin
                if (mthi) m_hi = src1;
                if (mtlo) m_lo = src1;
            end
        end
    end

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_busy", busy, (m_left > 0));
            check("cyc_done", done, m_done);
            check("cyc_div_zero", dz, m_dz);
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'd0;
            1: pick = 32'hffff_ffff;
            2: pick = 32'h8000_0000;
            3: pick = $urandom_range(0, 15);
            default: pick = $urandom;
        endcase
    endfunction

    // Issue one op from the current cycle and wait for done; optional mid-op
    // interference (kick_at) or reset (rst_at), -1 meaning none.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int kick_at, input int rst_at);
        int lat;
        start = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (lat < 60 && done !== 1'b1) begin
            if (lat == 1 || lat == W + 1) check("busy_window", {busy, done}, 2'b10);
            if (lat == kick_at) begin
                start = 1'b1;
                op = 2'b10;
                src1 = ~a;
                src2 = 32'h1234;
            end
            if (lat == kick_at + 1) begin
                start = 1'b0;
                src1 = $urandom;
                src2 = $urandom;
            end
            if (lat == rst_at) begin
                rst = 1'b1;
                #1;
                check("reset_async_status", {busy, done, dz}, 3'b000);
                check("reset_async_hilo", {hi, lo}, 64'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, W + 2);
        check("done_pulse", {done, busy}, 2'b10);
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic        edz;

        start = 1'b0;
        op = 2'b00;
        src1 = '0;
        src2 = '0;
        mthi = 1'b0;
        mtlo = 1'b0;

        // Pin the reference model with hand-computed results.
        ref_op(2'b01, 32'hffff_ffff, 32'hffff_ffff, eh, el, edz);
        check("model_multu", {eh, el}, 64'hffff_fffe_0000_0001);
        ref_op(2'b00, 32'hffff_fffd, 32'd7, eh, el, edz);
        check("model_mult", {eh, el}, 64'hffff_ffff_ffff_ffeb);
        ref_op(2'b10, 32'hffff_fff9, 32'd2, eh, el, edz);
        check("model_div", {eh, el}, 64'hffff_ffff_ffff_fffd);
        ref_op(2'b10, 32'h8000_0000, 32'hffff_ffff, eh, el, edz);
        check("model_div_ovf", {edz, eh, el}, {1'b0, 64'h0000_0000_8000_0000});
        ref_op(2'b11, 32'h1234_5678, 32'd0, eh, el, edz);
        check("model_divu_zero", {edz, eh, el}, {1'b1, 64'h1234_5678_ffff_ffff});

        repeat (2) @(posedge clk);
        #1;
        check("reset_status", {busy, done, dz}, 3'b000);
        check("reset_hilo", {hi, lo}, 64'd0);
        chk_on = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(2'b01, 32'hffff_ffff, 32'hffff_ffff, -1, -1);
        check("multu_max", {hi, lo}, 64'hffff_fffe_0000_0001);
        @(posedge clk);
        #1;
        run_op(2'b00, 32'hffff_fffd, 32'd7, -1, -1);
        check("mult_neg", {hi, lo}, 64'hffff_ffff_ffff_ffeb);
        @(posedge clk);
        #1;
        run_op(2'b10, 32'hffff_fff9, 32'd2, -1, -1);
        check("div_neg", {hi, lo}, 64'hffff_ffff_ffff_fffd);
        run_op(2'b11, 32'd7, 32'd2, -1, -1);
        check("divu_b2b", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op(2'b10, 32'h1234_5678, 32'd0, -1, -1);
        check("div_zero_res", {dz, hi, lo}, {1'b1, 64'h1234_5678_ffff_ffff});
        run_op(2'b10, 32'h8000_0000, 32'hffff_ffff, -1, -1);
        check("div_ovf_res", {dz, hi, lo}, {1'b0, 64'h0000_0000_8000_0000});
        @(posedge clk);
        #1;
        run_op(2'b01, 32'h0001_0003, 32'h0000_ffff, 5, -1);
        check("multu_ignore_start", {hi, lo}, 64'h0000_0001_0001_fffd);
        @(posedge clk);
        #1;

        mthi = 1'b1;
        src1 = 32'haaaa_5555;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check("mthi_hi", hi, 32'haaaa_5555);
        check("mthi_lo_kept", lo, 32'h0001_fffd);
        check("mthi_no_done", done, 1'b0);

        run_op(2'b01, 32'd7, 32'd9, -1, 10);
        run_op(2'b01, 32'd3, 32'd5, -1, -1);
        check("multu_after_reset", {hi, lo}, 64'd15);

        // Random traffic: starts, moves and stray inputs while busy, rare resets.
        for (int i = 0; i < 6000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            op = 2'($urandom_range(0, 3));
            src1 = pick();
            src2 = pick();
            mthi = ($urandom_range(0, 9) == 0);
            mtlo = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 2999) == 0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
